// File: rtl/sop_sweeper_if.sv
// Bus bundle for sop_sweeper: function config, single-eval handshake, sweep control and results.
// SOP_TERM_HITS_EN adds the per-term hit vector.
interface sop_sweeper_if #(
    parameter int NUM_VARS  = 4,
    parameter int NUM_TERMS = 4
);
    logic [NUM_VARS*NUM_TERMS-1:0] term_care;
    logic [NUM_VARS*NUM_TERMS-1:0] term_pol;
    logic                          out_inv;
    logic                          eval_valid;
    logic [NUM_VARS-1:0]           eval_vars;
    logic                          eval_ready;
    logic                          result_valid;
    logic                          result;
    logic                          start;
    logic                          busy;
    logic                          done;
    logic [(1<<NUM_VARS)-1:0]      truth_table;
    logic [NUM_VARS:0]             minterm_count;
    logic [1:0]                    dbg_state;
`ifdef SOP_TERM_HITS_EN
    logic [NUM_TERMS-1:0]          term_hits;
`endif

    modport master (
`ifdef SOP_TERM_HITS_EN
        input  term_hits,
`endif
        output term_care, term_pol, out_inv, eval_valid, eval_vars, start,
        input  eval_ready, result_valid, result, busy, done, truth_table,
               minterm_count, dbg_state
    );

    modport slave (
`ifdef SOP_TERM_HITS_EN
        output term_hits,
`endif
        input  term_care, term_pol, out_inv, eval_valid, eval_vars, start,
        output eval_ready, result_valid, result, busy, done, truth_table,
               minterm_count, dbg_state
    );
endinterface

// File: rtl/sop_sweeper.sv
// Programmable sum-of-products engine: registered single evaluation plus a sweep FSM
// that captures the whole truth table. Optional macro SOP_TERM_HITS_EN exposes per-term hits.
module sop_sweeper #(
    parameter int NUM_VARS  = 4,
    parameter int NUM_TERMS = 4
) (
    input  logic          clk,
    input  logic          rst,
    sop_sweeper_if.slave  bus
);
    localparam int NC = NUM_VARS * NUM_TERMS;
    localparam int TT = 1 << NUM_VARS;
    localparam int IW = NUM_VARS + 1;
    localparam logic [IW-1:0] LAST = IW'(TT - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, SWEEP = 2'd1, DONE = 2'd2} state_t;

    state_t               state_q, state_d;
    logic [IW-1:0]        index_q, index_d;
    logic [NC-1:0]        care_q, care_d;
    logic [NC-1:0]        pol_q, pol_d;
    logic                 inv_q, inv_d;
    logic [TT-1:0]        table_q, table_d;
    logic [IW-1:0]        count_q, count_d;
    logic                 result_q, result_d;
    logic                 rvalid_q, rvalid_d;
    logic [NUM_TERMS-1:0] hits_q, hits_d;

    logic [NUM_TERMS-1:0] live_hits;
    logic [NUM_TERMS-1:0] sweep_hits;
    logic                 sweep_f;
    logic                 eval_accept;

    function automatic logic [NUM_TERMS-1:0] term_hits_f(
        input logic [NC-1:0]       care,
        input logic [NC-1:0]       pol,
        input logic [NUM_VARS-1:0] vars
    );
        logic [NUM_TERMS-1:0] h;
        for (int t = 0; t < NUM_TERMS; t++) begin
            h[t] = 1'b1;
            for (int v = 0; v < NUM_VARS; v++) begin
                h[t] = h[t] & (~care[t*NUM_VARS+v] | (vars[v] ~^ pol[t*NUM_VARS+v]));
            end
        end
        return h;
    endfunction

    // Single eval handshake: a request transfers on a rising edge where eval_valid && eval_ready;
    // eval_ready is low for the whole sweep, and the result is a one-cycle result_valid pulse.
    always_comb begin
        live_hits   = term_hits_f(bus.term_care, bus.term_pol, bus.eval_vars);
        sweep_hits  = term_hits_f(care_q, pol_q, index_q[NUM_VARS-1:0]);
        sweep_f     = (|sweep_hits) ^ inv_q;
        eval_accept = bus.eval_valid && (state_q == IDLE);

        state_d  = state_q;
        index_d  = index_q;
        care_d   = care_q;
        pol_d    = pol_q;
        inv_d    = inv_q;
        table_d  = table_q;
        count_d  = count_q;
        result_d = result_q;
        hits_d   = hits_q;
        rvalid_d = eval_accept;

        if (eval_accept) begin
            result_d = (|live_hits) ^ bus.out_inv;
            hits_d   = live_hits;
        end

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    care_d  = bus.term_care;
                    pol_d   = bus.term_pol;
                    inv_d   = bus.out_inv;
                    index_d = '0;
                    table_d = '0;
                    count_d = '0;
                    state_d = SWEEP;
                end
            end
            SWEEP: begin
                table_d[index_q[NUM_VARS-1:0]] = sweep_f;
                count_d = count_q + IW'(sweep_f);
                if (index_q == LAST) begin
                    state_d = DONE;
                end else begin
                    index_d = index_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            index_q  <= '0;
            care_q   <= '0;
            pol_q    <= '0;
            inv_q    <= 1'b0;
            table_q  <= '0;
            count_q  <= '0;
            result_q <= 1'b0;
            rvalid_q <= 1'b0;
            hits_q   <= '0;
        end else begin
            state_q  <= state_d;
            index_q  <= index_d;
            care_q   <= care_d;
            pol_q    <= pol_d;
            inv_q    <= inv_d;
            table_q  <= table_d;
            count_q  <= count_d;
            result_q <= result_d;
            rvalid_q <= rvalid_d;
            hits_q   <= hits_d;
        end
    end

    assign bus.busy          = (state_q != IDLE);
    assign bus.eval_ready    = (state_q == IDLE);
    assign bus.done          = (state_q == DONE);
    assign bus.result        = result_q;
    assign bus.result_valid  = rvalid_q;
    assign bus.truth_table   = table_q;
    assign bus.minterm_count = count_q;
    assign bus.dbg_state     = state_q;
`ifdef SOP_TERM_HITS_EN
    assign bus.term_hits     = hits_q;
`else
    logic unused_hits;
    assign unused_hits = ^hits_q;
`endif
endmodule

// File: tb/tb_sop_sweeper.sv
// Directed bench for sop_sweeper with a scoreboard model of the sum-of-products function.
// Build with SOP_TERM_HITS_EN defined to also check the per-term hit vector.
module tb_sop_sweeper;
  localparam int NV = 4;
  localparam int NT = 4;
  localparam int NC = NV * NT;
  localparam int TT = 1 << NV;
  localparam int W  = TT + NV + 1;

  logic clk = 1'b0;
  logic rst;

  sop_sweeper_if #(.NUM_VARS(NV), .NUM_TERMS(NT)) bus ();
  sop_sweeper #(.NUM_VARS(NV), .NUM_TERMS(NT)) dut (.clk(clk), .rst(rst), .bus(bus));

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int rv_cnt = 0;
  logic [W-1:0] exp_q[$];
  logic [NT:0]  res_q[$];

  always @(negedge clk) begin
    if (bus.done) done_cnt++;
    if (bus.result_valid) rv_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // model: {hits, F}; a term hits when no cared variable differs from its polarity
  function automatic logic [NT:0] model(input logic [NC-1:0] care, input logic [NC-1:0] pol,
                                        input logic inv, input logic [NV-1:0] x);
    logic [NT-1:0] h;
    for (int t = 0; t < NT; t++)
      h[t] = (((x ^ pol[t*NV +: NV]) & care[t*NV +: NV]) == '0);
    return {h, (|h) ^ inv};
  endfunction

  function automatic logic [W-1:0] model_table(input logic [NC-1:0] care, input logic [NC-1:0] pol,
                                               input logic inv);
    logic [TT-1:0] tt;
    logic [NV:0]   cnt;
    logic [NT:0]   r;
    cnt = '0;
    for (int i = 0; i < TT; i++) begin
      r = model(care, pol, inv, NV'(i));
      tt[i] = r[0];
      if (r[0]) cnt = cnt + 1'b1;
    end
    return {cnt, tt};
  endfunction

  // driver tasks
  task automatic do_eval(input logic [NV-1:0] v);
    logic [NT:0] e;
    bus.eval_vars  = v;
    bus.eval_valid = 1'b1;
    res_q.push_back(model(bus.term_care, bus.term_pol, bus.out_inv, v));
    step();
    bus.eval_valid = 1'b0;
    e = res_q.pop_front();
    check("eval_rv", 32'(bus.result_valid), 32'd1);
    check("eval_result", 32'(bus.result), 32'(e[0]));
`ifdef SOP_TERM_HITS_EN
    check("eval_hits", 32'(bus.term_hits), 32'(e[NT:1]));
`endif
    step();
    check("eval_rv_drop", 32'(bus.result_valid), 32'd0);
    check("eval_result_hold", 32'(bus.result), 32'(e[0]));
  endtask

  task automatic run_sweep(input logic [NC-1:0] care, input logic [NC-1:0] pol, input logic inv,
                           input int disturb, output logic [TT-1:0] tt_o, output logic [NV:0] cnt_o);
    logic [W-1:0] e;
    int cyc;
    int d0;
    int r0;
    bus.term_care = care;
    bus.term_pol  = pol;
    bus.out_inv   = inv;
    bus.start     = 1'b1;
    exp_q.push_back(model_table(care, pol, inv));
    d0 = done_cnt;
    r0 = rv_cnt;
    step();
    bus.start = 1'b0;
    check("sweep_busy", 32'(bus.busy), 32'd1);
    check("sweep_ready_low", 32'(bus.eval_ready), 32'd0);
    cyc = 1;
    while (!bus.done && cyc < 40) begin
      if (cyc == disturb) begin
        bus.term_care  = '0;
        bus.start      = 1'b1;
        bus.eval_valid = 1'b1;
        bus.eval_vars  = 4'b0100;
      end
      step();
      bus.start      = 1'b0;
      bus.eval_valid = 1'b0;
      cyc++;
    end
    check("done_latency", 32'(cyc), 32'd17);
    e = exp_q.pop_front();
    check("sweep_table", 32'(bus.truth_table), 32'(e[TT-1:0]));
    check("sweep_count", 32'(bus.minterm_count), 32'(e[W-1:TT]));
    tt_o  = bus.truth_table;
    cnt_o = bus.minterm_count;
    step();
    check("done_drop", 32'(bus.done), 32'd0);
    check("idle_after_done", 32'(bus.busy), 32'd0);
    check("table_hold", 32'(bus.truth_table), 32'(e[TT-1:0]));
    check("one_done_pulse", 32'(done_cnt - d0), 32'd1);
    check("no_rv_in_sweep", 32'(rv_cnt - r0), 32'd0);
    bus.term_care = care;
  endtask

  localparam logic [NC-1:0] CARE = 16'h596C;
  localparam logic [NC-1:0] POL  = 16'h5844;

  initial begin
    logic [TT-1:0] tt;
    logic [NV:0]   cnt;
    int d0;
    rst            = 1'b1;
    bus.term_care  = '0;
    bus.term_pol   = '0;
    bus.out_inv    = 1'b0;
    bus.eval_valid = 1'b0;
    bus.eval_vars  = '0;
    bus.start      = 1'b0;
    step();
    step();
    check("rst_table", 32'(bus.truth_table), 32'd0);
    check("rst_count", 32'(bus.minterm_count), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_ready", 32'(bus.eval_ready), 32'd1);
    check("rst_state", 32'(bus.dbg_state), 32'd0);
    rst = 1'b0;
    step();

    // plain and inverted sweeps of the reference function
    run_sweep(CARE, POL, 1'b0, 0, tt, cnt);
    check("tp1_table", 32'(tt), 32'hF5F0);
    check("tp1_count", 32'(cnt), 32'd10);
    run_sweep(CARE, POL, 1'b1, 0, tt, cnt);
    check("tp2_table", 32'(tt), 32'h0A0F);
    check("tp2_count", 32'(cnt), 32'd6);

    // single evaluations
    bus.out_inv = 1'b0;
    do_eval(4'b0100);
    check("tp3_result_one", 32'(bus.result), 32'd1);
    do_eval(4'b0000);
    check("tp3_result_zero", 32'(bus.result), 32'd0);
    for (int i = 0; i < 6; i++) begin
      bus.out_inv = 1'($urandom_range(0, 1));
      do_eval(NV'($urandom_range(0, TT - 1)));
    end
    bus.out_inv = 1'b0;

    // config change, start and eval while busy are all ignored
    run_sweep(CARE, POL, 1'b0, 5, tt, cnt);
    check("tp4_table", 32'(tt), 32'hF5F0);

    // asynchronous reset mid-sweep
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (7) step();
    d0 = done_cnt;
    #2 rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_table", 32'(bus.truth_table), 32'd0);
    check("mid_rst_count", 32'(bus.minterm_count), 32'd0);
    check("mid_rst_result", 32'(bus.result), 32'd0);
    check("mid_rst_done", 32'(bus.done), 32'd0);
    step();
    rst = 1'b0;
    repeat (20) step();
    check("no_done_after_rst", 32'(done_cnt - d0), 32'd0);
    check("idle_after_rst", 32'(bus.dbg_state), 32'd0);
    run_sweep(CARE, POL, 1'b0, 0, tt, cnt);
    check("tp5_table", 32'(tt), 32'hF5F0);

    // all-zero care masks: every term always hits
    run_sweep('0, POL, 1'b0, 0, tt, cnt);
    check("tp6_table", 32'(tt), 32'hFFFF);
    check("tp6_count", 32'(cnt), 32'd16);

    // random configuration
    run_sweep(NC'($urandom), NC'($urandom), 1'($urandom_range(0, 1)), 0, tt, cnt);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sop_sweeper.md
Name: sop_sweeper

Overview:
- Parametrised sum-of-products evaluator over NUM_VARS inputs and NUM_TERMS programmable product terms, with optional output inversion.
- Two modes:
  - Registered single evaluation of one input vector.
  - Sweep FSM that walks all 2^NUM_VARS input combinations and captures the full truth table plus a minterm count.
- Serves as the reusable boolean-function engine for lab exercises and self-checking benches in place of fixed hand-wired gate networks.

Parameters:
- NUM_VARS, 4, number of boolean inputs; legal range 1..10.
- NUM_TERMS, 4, number of product terms OR-ed together; legal range 1..16.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- term_care  in  NUM_VARS*NUM_TERMS  per-term care mask; term t occupies [t*NUM_VARS +: NUM_VARS]; bit=1 means the variable participates.
- term_pol  in  NUM_VARS*NUM_TERMS  per-term literal polarity, same packing; 1 = true literal, 0 = complemented.
- out_inv  in  1  invert the final OR result.
- eval_valid  in  1  request single evaluation of eval_vars.
- eval_vars  in  NUM_VARS  input vector; bit NUM_VARS-1 is variable A (MSB).
- eval_ready  out  1  equals ~busy.
- result_valid  out  1  one-cycle pulse, single-eval result valid.
- result  out  1  single-eval function value.
- start  in  1  begin sweep.
- busy  out  1  sweep in progress (SWEEP or DONE state).
- done  out  1  one-cycle pulse at sweep completion.
- truth_table  out  2^NUM_VARS  bit i = F(i).
- minterm_count  out  NUM_VARS+1  number of ones in truth_table.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, internal index and latched config cleared; takes effect immediately, including mid-sweep. No partial table survives.
- Term function: hit_t = AND over v of (~care[v] | (vars[v] ~^ pol[v])). A term with an all-zero care mask always hits.
- F = (OR of hit_t) ^ inv.
- Single eval:
  - Accepted when eval_valid && eval_ready.
  - Uses live term_care/term_pol/out_inv.
  - result_valid=1 and result=F on the next cycle; result holds its value until the next accepted eval.
  - eval_valid while busy is ignored, with no pulse.
- FSM states: IDLE, SWEEP, DONE.
- IDLE:
  - On start=1: latch term_care/term_pol/out_inv, set index=0, clear truth_table and minterm_count, go to SWEEP.
  - If start and eval_valid are both high in the same cycle, both are accepted; the eval result appears next cycle as normal.
- SWEEP:
  - Each cycle: truth_table[index] <= F(index) using the latched config; minterm_count += F.
  - When index == 2^NUM_VARS-1, go to DONE; otherwise index+1.
  - Config input changes during a sweep have no effect.
- DONE: done=1 for exactly one cycle, then IDLE.
- Latency: with start sampled at edge 0, done is high in cycle 2^NUM_VARS+1. truth_table and minterm_count are final when done is high and hold until the next start or reset.
- start while busy is ignored.
- Index width is NUM_VARS+1 internally, so the terminal compare never wraps. minterm_count can reach 2^NUM_VARS without overflow.

Optional Feature:
- Macro: SOP_TERM_HITS_EN.
- Defined:
  - Adds output term_hits [NUM_TERMS], registered alongside result on each accepted single eval.
  - Bit t = hit_t before out_inv is applied.
  - Reset value 0.
- Undefined: the port and its registers are absent; all other behaviour is identical.

Test Plan (defaults; A=bit3..D=bit0; F = A'B + BC' + AD' + BD, so term_care=0x596C, term_pol=0x5844):
1. out_inv=0, start pulse -> busy high, done after 17 cycles, truth_table=0xF5F0, minterm_count=10.
2. Same config with out_inv=1 -> truth_table=0x0A0F, minterm_count=6.
3. Single eval with eval_vars=4'b0100 -> result=1 next cycle. With SOP_TERM_HITS_EN: term_hits=4'b0011. Then eval_vars=4'b0000 -> result=0, term_hits=4'b0000.
4. Start a sweep; at cycle 5 change term_care to 0x0000 and pulse start and eval_valid -> final table still 0xF5F0, no result_valid pulse, only one done pulse.
5. Assert rst at cycle 8 of a sweep -> outputs 0 immediately, no done pulse. A new start afterwards yields 0xF5F0 after 17 cycles.
6. term_care=0x0000 (every term always hits), start -> truth_table=0xFFFF, minterm_count=16 (5'b10000).
